// File: rtl/apb_global_pkg.sv
// Shared APB types, memory-map constants and helpers for the APB master controller.
package apb_global_pkg;

  typedef enum logic { READ = 1'b0, WRITE = 1'b1 } tx_type_e;

  typedef enum logic [2:0] {
    NORMAL_SECURE_DATA          = 3'b000,
    PRIVILEGED_SECURE_DATA      = 3'b001,
    NORMAL_NONSECURE_DATA       = 3'b010,
    PRIVILEGED_NONSECURE_DATA   = 3'b011,
    NORMAL_SECURE_INSTR         = 3'b100,
    PRIVILEGED_SECURE_INSTR     = 3'b101,
    NORMAL_NONSECURE_INSTR      = 3'b110,
    PRIVILEGED_NONSECURE_INSTR  = 3'b111
  } protection_type_e;

  typedef enum logic [3:0] {
    SLAVE_0, SLAVE_1, SLAVE_2,  SLAVE_3,  SLAVE_4,  SLAVE_5,  SLAVE_6,  SLAVE_7,
    SLAVE_8, SLAVE_9, SLAVE_10, SLAVE_11, SLAVE_12, SLAVE_13, SLAVE_14, SLAVE_15
  } slave_no_e;

  typedef enum logic [1:0] { IDLE, SETUP, ACCESS, RESP } apb_ctrl_state_e;

  localparam int SLAVE_MEMORY_SIZE_KB = 12;
  localparam int SLAVE_MEMORY_GAP_KB  = 2;
  localparam int SLAVE_REGION_BYTES   = SLAVE_MEMORY_SIZE_KB * 1024;
  localparam int SLAVE_STRIDE_BYTES   = (SLAVE_MEMORY_SIZE_KB + SLAVE_MEMORY_GAP_KB) * 1024;

  function automatic int slave_base_addr(int id);
    return id * SLAVE_STRIDE_BYTES;
  endfunction

endpackage

// File: rtl/apb_addr_decoder.sv
// Combinational address decode: byte address -> one-hot slave select or decode error.
module apb_addr_decoder
  import apb_global_pkg::*;
#(
  parameter int NO_OF_SLAVES  = 4,
  parameter int ADDRESS_WIDTH = 32,
  parameter int REGION_BYTES  = SLAVE_REGION_BYTES,
  parameter int STRIDE_BYTES  = SLAVE_STRIDE_BYTES
) (
  input  logic [ADDRESS_WIDTH-1:0] addr,
  output logic [NO_OF_SLAVES-1:0]  sel,
  output logic                     decode_error
);
  localparam int AW1 = ADDRESS_WIDTH + 1;

  // One extra bit so base+region never wraps for the top slave.
  logic [AW1-1:0] addr_x;
  assign addr_x = {1'b0, addr};

  for (genvar i = 0; i < NO_OF_SLAVES; i++) begin : g_sel
    localparam logic [AW1-1:0] BASE  = AW1'(i * STRIDE_BYTES);
    localparam logic [AW1-1:0] LIMIT = AW1'(i * STRIDE_BYTES + REGION_BYTES);
    assign sel[i] = (addr_x >= BASE) && (addr_x < LIMIT);
  end

  assign decode_error = (sel == '0);

endmodule

// File: rtl/apb_master_controller.sv
// Single-outstanding APB master: command in, IDLE/SETUP/ACCESS/RESP sequencing, response out.
module apb_master_controller
  import apb_global_pkg::*;
#(
  parameter int NO_OF_SLAVES      = 4,
  parameter int ADDRESS_WIDTH     = 32,
  parameter int DATA_WIDTH        = 32,
  parameter int SLAVE_MEMORY_SIZE = 12,
  parameter int SLAVE_MEMORY_GAP  = 2,
  parameter int MAX_WAIT_STATES   = 16
) (
  input  logic                      pclk,
  input  logic                      preset_n,
  input  logic                      cmd_valid,
  output logic                      cmd_ready,
  input  logic                      cmd_write,
  input  logic [ADDRESS_WIDTH-1:0]  cmd_addr,
  input  logic [DATA_WIDTH-1:0]     cmd_wdata,
  input  logic [DATA_WIDTH/8-1:0]   cmd_strb,
  input  logic [2:0]                cmd_prot,
  output logic                      rsp_valid,
  input  logic                      rsp_ready,
  output logic [DATA_WIDTH-1:0]     rsp_rdata,
  output logic                      rsp_slverr,
  output logic                      rsp_decerr,
  output logic                      rsp_timeout,
  output logic [ADDRESS_WIDTH-1:0]  paddr,
  output logic [NO_OF_SLAVES-1:0]   pselx,
  output logic                      penable,
  output logic                      pwrite,
  output logic [DATA_WIDTH-1:0]     pwdata,
  output logic [DATA_WIDTH/8-1:0]   pstrb,
  output logic [2:0]                pprot,
  input  logic                      pready,
  input  logic [DATA_WIDTH-1:0]     prdata,
  input  logic                      pslverr
);
  localparam int SW     = DATA_WIDTH / 8;
  localparam int WAIT_W = $clog2(MAX_WAIT_STATES + 1);

  apb_ctrl_state_e           state_q, state_d;
  logic [ADDRESS_WIDTH-1:0]  addr_q, addr_d;
  logic [DATA_WIDTH-1:0]     wdata_q, wdata_d;
  logic [SW-1:0]             strb_q, strb_d;
  logic [2:0]                prot_q, prot_d;
  logic                      write_q, write_d;
  logic [NO_OF_SLAVES-1:0]   sel_q, sel_d;
  logic [WAIT_W-1:0]         wait_q, wait_d;
  logic [DATA_WIDTH-1:0]     rdata_q, rdata_d;
  logic                      slverr_q, slverr_d;
  logic                      decerr_q, decerr_d;
  logic                      timeout_q, timeout_d;

  logic [NO_OF_SLAVES-1:0]   dec_sel;
  logic                      dec_err;

  apb_addr_decoder #(
    .NO_OF_SLAVES  (NO_OF_SLAVES),
    .ADDRESS_WIDTH (ADDRESS_WIDTH),
    .REGION_BYTES  (SLAVE_MEMORY_SIZE * 1024),
    .STRIDE_BYTES  ((SLAVE_MEMORY_SIZE + SLAVE_MEMORY_GAP) * 1024)
  ) u_dec (
    .addr         (cmd_addr),
    .sel          (dec_sel),
    .decode_error (dec_err)
  );

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    strb_d    = strb_q;
    prot_d    = prot_q;
    write_d   = write_q;
    sel_d     = sel_q;
    wait_d    = wait_q;
    rdata_d   = rdata_q;
    slverr_d  = slverr_q;
    decerr_d  = decerr_q;
    timeout_d = timeout_q;
    unique case (state_q)
      IDLE: if (cmd_valid) begin
        write_d = (tx_type_e'(cmd_write) == WRITE);
        addr_d  = cmd_addr;
        wdata_d = write_d ? cmd_wdata : '0;
        strb_d  = write_d ? cmd_strb  : '0;
        prot_d  = cmd_prot;
        sel_d   = dec_sel;
        wait_d  = '0;
        if (dec_err) begin
          decerr_d = 1'b1;
          state_d  = RESP;
        end else begin
          state_d  = SETUP;
        end
      end
      SETUP: state_d = ACCESS;
      ACCESS: begin
        // prdata/pslverr are only meaningful on the pready=1 cycle.
        if (pready) begin
          rdata_d  = write_q ? '0 : prdata;
          slverr_d = pslverr;
          state_d  = RESP;
        end else begin
          wait_d = wait_q + 1'b1;
          if (wait_d == WAIT_W'(MAX_WAIT_STATES)) begin
            timeout_d = 1'b1;
            state_d   = RESP;
          end
        end
      end
      RESP: if (rsp_ready) begin
        rdata_d   = '0;
        slverr_d  = 1'b0;
        decerr_d  = 1'b0;
        timeout_d = 1'b0;
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge pclk) begin
    if (!preset_n) begin
      state_q   <= IDLE;
      addr_q    <= '0;
      wdata_q   <= '0;
      strb_q    <= '0;
      prot_q    <= '0;
      write_q   <= 1'b0;
      sel_q     <= '0;
      wait_q    <= '0;
      rdata_q   <= '0;
      slverr_q  <= 1'b0;
      decerr_q  <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      strb_q    <= strb_d;
      prot_q    <= prot_d;
      write_q   <= write_d;
      sel_q     <= sel_d;
      wait_q    <= wait_d;
      rdata_q   <= rdata_d;
      slverr_q  <= slverr_d;
      decerr_q  <= decerr_d;
      timeout_q <= timeout_d;
    end
  end

  assign cmd_ready   = (state_q == IDLE);
  assign rsp_valid   = (state_q == RESP);
  assign rsp_rdata   = rdata_q;
  assign rsp_slverr  = slverr_q;
  assign rsp_decerr  = decerr_q;
  assign rsp_timeout = timeout_q;
  assign pselx       = (state_q == SETUP || state_q == ACCESS) ? sel_q : '0;
  assign penable     = (state_q == ACCESS);
  assign paddr       = addr_q;
  assign pwrite      = write_q;
  assign pwdata      = wdata_q;
  assign pstrb       = strb_q;
  assign pprot       = prot_q;

endmodule
